// File: rtl/sig_change_logger_pkg.sv
// Shared definitions for the signal change logger.
// Provides the default parameter values, the packed event record at those
// default widths and the toggle-mask helper.
package sig_change_logger_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] prev;
        logic [WIDTH_DEF-1:0] curr;
        logic [WIDTH_DEF-1:0] mask;
        logic [TS_W_DEF-1:0]  ts;
    } chg_evt_t;

    function automatic logic [WIDTH_DEF-1:0] chg_mask(input logic [WIDTH_DEF-1:0] prev,
                                                      input logic [WIDTH_DEF-1:0] curr);
        return prev ^ curr;
    endfunction

endpackage

// File: rtl/chg_evt_fifo.sv
// Generic show-ahead synchronous FIFO.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (control state only)
//   i_flush      synchronous flush, wins over push/pop
//   i_push/i_din write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   i_pop        read request; ignored when empty
//   o_dout       head entry (valid while !o_empty)
//   o_full, o_empty, o_count  occupancy status
module chg_evt_fifo
    import sig_change_logger_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_din,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign w_push  = i_push & (~o_full | w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sig_change_logger.sv
// Synchronous change monitor.
// Samples sig_i every enabled clock and queues one event per change:
// {previous value, new value, toggle mask, timestamp of the sample}.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en_i             sampling enable (0 freezes timestamp and previous value)
//   clear_i          synchronous flush: empties queue, clears overflow,
//                    zeroes timestamp, disarms
//   sig_i            monitored vector
//   evt_valid_o/evt_ready_i  show-ahead read handshake
//   evt_prev_o, evt_curr_o, evt_mask_o, evt_time_o   head event fields
//   count_o          events queued
//   overflow_o       sticky: an event was dropped while the queue was full
module sig_change_logger
    import sig_change_logger_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           sig_i,
    output logic                       evt_valid_o,
    input  logic                       evt_ready_i,
    output logic [WIDTH-1:0]           evt_prev_o,
    output logic [WIDTH-1:0]           evt_curr_o,
    output logic [WIDTH-1:0]           evt_mask_o,
    output logic [TS_W-1:0]            evt_time_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int DATA_W = 3*WIDTH + TS_W;

    logic [TS_W-1:0]   r_ts;
    logic [WIDTH-1:0]  r_prev;
    logic              r_armed;
    logic              r_overflow;

    logic              w_detect;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_dout;
    logic              w_full;
    logic              w_empty;
    logic              w_valid;
    logic [WIDTH-1:0]  w_h_prev;
    logic [WIDTH-1:0]  w_h_curr;
    logic [WIDTH-1:0]  w_h_mask;
    logic [TS_W-1:0]   w_h_time;

    // The arming sample only loads r_prev; detection starts on the sample after.
    assign w_detect = r_armed & en_i & ~clear_i & (sig_i != r_prev);
    assign w_din    = {r_prev, sig_i, r_prev ^ sig_i, r_ts};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_ts       <= '0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (en_i) begin
                r_ts    <= r_ts + 1'b1;
                r_prev  <= sig_i;
                r_armed <= 1'b1;
            end
            // Full implies valid, so ready alone tells whether a slot frees up.
            if (w_detect && w_full && !evt_ready_i) r_overflow <= 1'b1;
        end
    end

    chg_evt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (clear_i),
        .i_push  (w_detect),
        .i_din   (w_din),
        .i_pop   (evt_ready_i),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o)
    );

    assign w_valid = ~w_empty;
    assign {w_h_prev, w_h_curr, w_h_mask, w_h_time} = w_dout;

    // Storage is not reset, so head fields are forced to zero while empty.
    assign evt_valid_o = w_valid;
    assign evt_prev_o  = w_valid ? w_h_prev : '0;
    assign evt_curr_o  = w_valid ? w_h_curr : '0;
    assign evt_mask_o  = w_valid ? w_h_mask : '0;
    assign evt_time_o  = w_valid ? w_h_time : '0;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_sig_change_logger.sv
module tb_sig_change_logger;

    localparam int W  = 3;
    localparam int D  = 8;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          en_i;
    logic          clear_i;
    logic [W-1:0]  sig_i;
    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [W-1:0]  evt_prev_o;
    logic [W-1:0]  evt_curr_o;
    logic [W-1:0]  evt_mask_o;
    logic [TW-1:0] evt_time_o;
    logic [3:0]    count_o;
    logic          overflow_o;

    sig_change_logger #(.WIDTH(W), .DEPTH(D), .TS_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .clear_i     (clear_i),
        .sig_i       (sig_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_prev_o  (evt_prev_o),
        .evt_curr_o  (evt_curr_o),
        .evt_mask_o  (evt_mask_o),
        .evt_time_o  (evt_time_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of events plus the few pieces of state the rules name.
    typedef struct {
        logic [W-1:0]  p;
        logic [W-1:0]  c;
        logic [W-1:0]  m;
        logic [TW-1:0] t;
    } ev_t;

    ev_t           mq[$];
    int            m_ts;
    logic [W-1:0]  m_prev;
    bit            m_armed;
    bit            m_ovf;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts    = 0;
        m_prev  = '0;
        m_armed = 0;
        m_ovf   = 0;
    endtask

    task automatic model_edge(input logic en, input logic clr, input logic [W-1:0] s, input logic rdy);
        ev_t e;
        if (clr) begin
            mq.delete();
            m_ovf   = 0;
            m_ts    = 0;
            m_armed = 0;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (m_armed && en && s != m_prev) begin
                e.p = m_prev;
                e.c = s;
                e.m = m_prev ^ s;
                e.t = TW'(m_ts);
                if (mq.size() < D) mq.push_back(e);
                else m_ovf = 1;
            end
            if (en) begin
                m_prev  = s;
                m_armed = 1;
                m_ts    = (m_ts + 1) % (1 << TW);
            end
        end
    endtask

    task automatic compare();
        chk("valid", 32'(evt_valid_o), 32'(mq.size() != 0));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("head_prev", 32'(evt_prev_o), 32'(mq[0].p));
            chk("head_curr", 32'(evt_curr_o), 32'(mq[0].c));
            chk("head_mask", 32'(evt_mask_o), 32'(mq[0].m));
            chk("head_time", 32'(evt_time_o), 32'(mq[0].t));
        end else begin
            chk("idle_fields", 32'({evt_prev_o, evt_curr_o, evt_mask_o, evt_time_o}), 32'd0);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic [W-1:0] s, input logic rdy);
        en_i        = en;
        clear_i     = clr;
        sig_i       = s;
        evt_ready_i = rdy;
        @(posedge clk);
        model_edge(en, clr, s, rdy);
        #1;
        compare();
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 1'b1;
        en_i = 1'b0;
        clear_i = 1'b0;
        sig_i = '0;
        evt_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst = 1'b0;

        // First enabled cycle only arms.
        step(1, 0, 3'b101, 0);
        chk("arm_no_event", 32'(count_o), 32'd0);
        repeat (4) step(1, 0, 3'b000, 1);
        step(1, 0, 3'b011, 1);
        chk("t5_valid", 32'(evt_valid_o), 32'd1);
        chk("t5_prev", 32'(evt_prev_o), 32'd0);
        chk("t5_curr", 32'(evt_curr_o), 32'd3);
        chk("t5_mask", 32'(evt_mask_o), 32'd3);
        chk("t5_time", 32'(evt_time_o), 32'd5);

        // Overflow: nine changes with the consumer stalled.
        step(1, 0, 3'b011, 1);
        v = 3'b011;
        for (int i = 0; i < 9; i++) begin
            v = v + 3'd1;
            step(1, 0, v, 0);
        end
        chk("ovf_count", 32'(count_o), 32'd8);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_head_curr", 32'(evt_curr_o), 32'd4);
        repeat (8) step(0, 0, 3'b000, 1);
        chk("drained", 32'(count_o), 32'd0);

        // Full with simultaneous push and pop.
        step(1, 1, 3'b000, 0);
        step(1, 0, 3'b000, 0);
        v = 3'b000;
        for (int i = 0; i < 8; i++) begin
            v = v + 3'd1;
            step(1, 0, v, 0);
        end
        step(1, 0, 3'b101, 1);
        chk("full_pp_count", 32'(count_o), 32'd8);
        chk("full_pp_ovf", 32'(overflow_o), 32'd0);

        // Clear with three queued, then re-arm without logging.
        repeat (5) step(0, 0, 3'b101, 1);
        chk("three_left", 32'(count_o), 32'd3);
        step(1, 1, 3'b110, 0);
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_valid", 32'(evt_valid_o), 32'd0);
        step(1, 0, 3'b010, 0);
        chk("rearm_no_event", 32'(count_o), 32'd0);

        // Timestamp wrap: the change lands on the sample where ts is back at 0.
        repeat (15) step(1, 0, 3'b010, 0);
        step(1, 0, 3'b111, 0);
        chk("wrap_time", 32'(evt_time_o), 32'd0);
        chk("wrap_valid", 32'(evt_valid_o), 32'd1);

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            logic e, c, r;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 59) == 0);
            r = ((i / 80) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(e, c, W'($urandom_range(0, 7)), r);
        end

        // Asynchronous reset in the middle of a drain.
        step(1, 1, 3'b000, 0);
        step(1, 0, 3'b000, 0);
        step(1, 0, 3'b001, 0);
        step(1, 0, 3'b010, 0);
        step(1, 0, 3'b011, 0);
        step(0, 0, 3'b011, 1);
        chk("pre_rst_count", 32'(count_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        compare();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 3'b101, 0);
        step(1, 0, 3'b100, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
